// File: rtl/seq_pkg.sv
// Shared encodings for the micro-sequencer: opcodes, ALU ops, micro-states and
// instruction field positions.
package seq_pkg;

  localparam logic [3:0] OPC_LDI  = 4'd8;
  localparam logic [3:0] OPC_BRZ  = 4'd9;
  localparam logic [3:0] OPC_BRN  = 4'd10;
  localparam logic [3:0] OPC_BRO  = 4'd11;
  localparam logic [3:0] OPC_BRA  = 4'd12;
  localparam logic [3:0] OPC_OUT  = 4'd13;
  localparam logic [3:0] OPC_NOP  = 4'd14;
  localparam logic [3:0] OPC_HALT = 4'd15;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_INC = 3'b111;

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_PCUP  = 3'd4;
  localparam logic [2:0] S_PCWB  = 3'd5;
  localparam logic [2:0] S_HALT  = 3'd6;

  localparam int unsigned PC_REG = 7;

  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RA_LSB  = 6;
  localparam int unsigned RB_LSB  = 3;
  localparam int unsigned IMM_LSB = 0;

  function automatic logic is_branch(input logic [3:0] opc);
    return (opc == OPC_BRZ) || (opc == OPC_BRN) || (opc == OPC_BRO) || (opc == OPC_BRA);
  endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational control decode: maps (micro-state, IR, branch_taken) onto the
// datapath control bundle.
module seq_decode
  import seq_pkg::*;
#(
  parameter int unsigned M  = 3,
  parameter int unsigned N  = 8,
  parameter int unsigned IW = 16
) (
  input  logic [2:0]    state,
  input  logic [IW-1:0] ir,
  input  logic          branch_taken,
  output logic          instr_ready,
  output logic [N-1:0]  din,
  output logic [M-1:0]  waddr,
  output logic [M-1:0]  ra,
  output logic [M-1:0]  rb,
  output logic [2:0]    op,
  output logic          ie,
  output logic          write,
  output logic          reada,
  output logic          readb,
  output logic          en,
  output logic          oe,
  output logic [N-1:0]  offset,
  output logic          bypassa,
  output logic          bypassb,
  output logic          halted
);

  logic [3:0]   opc;
  logic [M-1:0] rd_f, ra_f, rb_f, pc_f;
  logic [7:0]   imm;
  logic         is_alu, is_ldi, is_out, is_br;

  assign opc    = ir[OPC_LSB +: 4];
  assign rd_f   = M'(ir[RD_LSB +: 3]);
  assign ra_f   = M'(ir[RA_LSB +: 3]);
  assign rb_f   = M'(ir[RB_LSB +: 3]);
  assign imm    = ir[IMM_LSB +: 8];
  assign pc_f   = M'(PC_REG);
  assign is_alu = ~opc[3];
  assign is_ldi = (opc == OPC_LDI);
  assign is_out = (opc == OPC_OUT);
  assign is_br  = is_branch(opc);

  always_comb begin
    instr_ready = 1'b0;
    din         = '0;
    waddr       = '0;
    ra          = '0;
    rb          = '0;
    op          = OP_ADD;
    ie          = 1'b0;
    write       = 1'b0;
    reada       = 1'b0;
    readb       = 1'b0;
    en          = 1'b0;
    oe          = 1'b0;
    offset      = '0;
    bypassa     = 1'b0;
    bypassb     = 1'b0;
    halted      = 1'b0;
    case (state)
      S_FETCH: begin
        // PC is driven onto dout so the instruction memory can be addressed.
        instr_ready = 1'b1;
        reada       = 1'b1;
        ra          = pc_f;
        oe          = 1'b1;
      end
      S_READ: begin
        if (is_alu || is_out) begin
          reada = 1'b1;
          readb = 1'b1;
          ra    = ra_f;
          rb    = rb_f;
        end
      end
      S_EXEC: begin
        if (is_alu) begin
          en    = 1'b1;
          op    = opc[2:0];
          reada = 1'b1;
          readb = 1'b1;
          ra    = ra_f;
          rb    = rb_f;
        end else if (is_ldi) begin
          ie  = 1'b1;
          din = N'(imm);
        end else if (is_out) begin
          oe    = 1'b1;
          reada = 1'b1;
          ra    = ra_f;
        end
      end
      S_WB: begin
        if (is_alu) begin
          write = 1'b1;
          waddr = rd_f;
        end else if (is_ldi) begin
          ie    = 1'b1;
          din   = N'(imm);
          write = 1'b1;
          waddr = rd_f;
        end
      end
      S_PCUP: begin
        ra    = pc_f;
        reada = 1'b1;
        en    = 1'b1;
        if (branch_taken) begin
          op      = OP_ADD;
          bypassb = 1'b1;
          offset  = N'($signed(imm));
        end else begin
          op = OP_INC;
        end
      end
      S_PCWB: begin
        write = 1'b1;
        waddr = pc_f;
        oe    = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microcoded control unit: fetches instructions, steps the micro-PC and drives
// the datapath controls through seq_decode.
module micro_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned M  = 3,
  parameter int unsigned N  = 8,
  parameter int unsigned IW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic          z_flag,
  input  logic          n_flag,
  input  logic          o_flag,
  output logic [N-1:0]  din,
  output logic [M-1:0]  waddr,
  output logic [M-1:0]  ra,
  output logic [M-1:0]  rb,
  output logic [2:0]    op,
  output logic          ie,
  output logic          write,
  output logic          reada,
  output logic          readb,
  output logic          en,
  output logic          oe,
  output logic [N-1:0]  offset,
  output logic          bypassa,
  output logic          bypassb,
  output logic [2:0]    upc,
  output logic          halted
);

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          branch_taken_q, branch_taken_d;
  logic [3:0]    opc;
  logic          flag_sel;

  logic          d_instr_ready, d_ie, d_write, d_reada, d_readb, d_en, d_oe;
  logic          d_bypassa, d_bypassb, d_halted;
  logic [N-1:0]  d_din, d_offset;
  logic [M-1:0]  d_waddr, d_ra, d_rb;
  logic [2:0]    d_op;

  assign opc = ir_q[OPC_LSB +: 4];

  always_comb begin
    flag_sel = 1'b1;
    case (opc)
      OPC_BRZ: flag_sel = z_flag;
      OPC_BRN: flag_sel = n_flag;
      OPC_BRO: flag_sel = o_flag;
      default: flag_sel = 1'b1;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    ir_d           = ir_q;
    branch_taken_d = branch_taken_q;
    case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: begin
        if (is_branch(opc)) branch_taken_d = flag_sel;
        state_d = (opc == OPC_HALT) ? S_HALT : S_WB;
      end
      S_WB:   state_d = S_PCUP;
      S_PCUP: state_d = S_PCWB;
      S_PCWB: begin
        branch_taken_d = 1'b0;
        state_d        = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_FETCH;
      ir_q           <= '0;
      branch_taken_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ir_q           <= ir_d;
      branch_taken_q <= branch_taken_d;
    end
  end

  seq_decode #(
    .M (M),
    .N (N),
    .IW(IW)
  ) u_decode (
    .state       (state_q),
    .ir          (ir_q),
    .branch_taken(branch_taken_q),
    .instr_ready (d_instr_ready),
    .din         (d_din),
    .waddr       (d_waddr),
    .ra          (d_ra),
    .rb          (d_rb),
    .op          (d_op),
    .ie          (d_ie),
    .write       (d_write),
    .reada       (d_reada),
    .readb       (d_readb),
    .en          (d_en),
    .oe          (d_oe),
    .offset      (d_offset),
    .bypassa     (d_bypassa),
    .bypassb     (d_bypassb),
    .halted      (d_halted)
  );

  // Forcing outputs low under rst is what suppresses a write cut off mid-instruction.
  assign instr_ready = rst ? 1'b0 : d_instr_ready;
  assign din         = rst ? '0   : d_din;
  assign waddr       = rst ? '0   : d_waddr;
  assign ra          = rst ? '0   : d_ra;
  assign rb          = rst ? '0   : d_rb;
  assign op          = rst ? '0   : d_op;
  assign ie          = rst ? 1'b0 : d_ie;
  assign write       = rst ? 1'b0 : d_write;
  assign reada       = rst ? 1'b0 : d_reada;
  assign readb       = rst ? 1'b0 : d_readb;
  assign en          = rst ? 1'b0 : d_en;
  assign oe          = rst ? 1'b0 : d_oe;
  assign offset      = rst ? '0   : d_offset;
  assign bypassa     = rst ? 1'b0 : d_bypassa;
  assign bypassb     = rst ? 1'b0 : d_bypassb;
  assign halted      = rst ? 1'b0 : d_halted;
  assign upc         = state_q;

endmodule
